dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port: accepts single-word load/store requests over a valid/ready handshake.
- Holds requests for a configurable number of wait states, then returns a one-cycle response with read data or an error flag.
- Sits between the datapath's load/store path and a word-organised data array, replacing the zero-latency plain data memory with a timed slave.

---
 rtl/dmem_responder_pkg.sv | 9 +
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder_word_array.sv | 17 +
 rtl/dmem_responder.sv | 59 +++++
 tb/tb_dmem_responder.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM state encoding and address field constants
package dmem_responder_pkg;
    typedef enum logic [1:0] {
        RSP_ST_IDLE = 2'd0,
        RSP_ST_WAIT = 2'd1,
        RSP_ST_RESP = 2'd2
    } rsp_state_e;
    localparam int BYTE_OFF_W = 2;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: valid/ready request and strobe response bus of the data-memory port
interface dmem_responder_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic [WORD_SIZE-1:0] rsp_rdata;
    logic                 rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_word_array.sv
// dmem_responder_word_array: word storage with synchronous write and combinational read
module dmem_responder_word_array #(
    parameter int WORD_SIZE  = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [WORD_SIZE-1:0]  i_wdata,
    output logic [WORD_SIZE-1:0]  o_rdata
);
    logic [WORD_SIZE-1:0] r_mem [2**DEPTH_LOG2];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end
    assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: timed data-memory slave returning one response WAIT_CYCLES+1 cycles after accept
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    rsp_state_e            r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_we;
    logic [WORD_SIZE-1:0]  r_addr, r_wdata, w_rdata;
    logic                  w_accept, w_resp, w_err, w_wr;
    logic [DEPTH_LOG2-1:0] w_idx;
    assign w_accept = bus.req_valid && r_state == RSP_ST_IDLE;
    assign w_resp   = r_state == RSP_ST_RESP;
    assign w_idx    = r_addr[DEPTH_LOG2+BYTE_OFF_W-1:BYTE_OFF_W];
    assign w_err    = |r_addr[BYTE_OFF_W-1:0] || |r_addr[WORD_SIZE-1:DEPTH_LOG2+BYTE_OFF_W];
    assign w_wr     = w_resp && r_we && !w_err && !rst;
    always_comb begin
        w_next        = r_state;
        w_next        = r_state == RSP_ST_IDLE ? (w_accept ? (WAIT_CYCLES == 0 ? RSP_ST_RESP : RSP_ST_WAIT) : RSP_ST_IDLE)
                      : r_state == RSP_ST_WAIT ? (r_cnt == '0 ? RSP_ST_RESP : RSP_ST_WAIT)
                      : RSP_ST_IDLE;
        bus.req_ready = r_state == RSP_ST_IDLE;
        bus.rsp_valid = w_resp;
        bus.rsp_err   = w_resp && w_err;
        bus.rsp_rdata = (w_resp && !r_we && !w_err) ? w_rdata : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RSP_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_cnt <= CW'(WAIT_CYCLES - 1);
            else if (r_state == RSP_ST_WAIT) r_cnt <= r_cnt - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end
    dmem_responder_word_array #(.WORD_SIZE(WORD_SIZE), .DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk     (clk),
        .i_we    (w_wr),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: deadline-based reference model checks a 2-wait and a 0-wait responder every cycle
module tb_dmem_responder;
    logic clk, rst;
    int checks = 0, errors = 0;
    dmem_responder_if #(.WORD_SIZE(32)) bus ();
    dmem_responder_if #(.WORD_SIZE(32)) bus_f ();
    assign bus_f.req_valid = bus.req_valid;
    assign bus_f.req_we    = bus.req_we;
    assign bus_f.req_addr  = bus.req_addr;
    assign bus_f.req_wdata = bus.req_wdata;
    dmem_responder #(.WORD_SIZE(32), .DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_main (.clk(clk), .rst(rst), .bus(bus));
    dmem_responder #(.WORD_SIZE(32), .DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_fast (.clk(clk), .rst(rst), .bus(bus_f));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic [31:0] mem [2][64];
    logic        busy [2];
    logic        pwe [2];
    logic [31:0] paddr [2], pwd [2];
    int          rcyc [2];
    int          cyc = 0;
    function automatic logic bad(input logic [31:0] a);
        return a[1:0] != 2'b0 || a[31:8] != 24'h0;
    endfunction
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    task automatic check_inst(input int k, input logic rdy, input logic vld, input logic [31:0] rd, input logic er);
        logic        ev;
        logic [31:0] erd;
        ev  = busy[k] && cyc == rcyc[k];
        erd = (ev && !pwe[k] && !bad(paddr[k])) ? mem[k][paddr[k][7:2]] : 32'h0;
        chk($sformatf("ready%0d@%0d", k, cyc), 32'(rdy), 32'(!busy[k]));
        chk($sformatf("valid%0d@%0d", k, cyc), 32'(vld), 32'(ev));
        chk($sformatf("rdata%0d@%0d", k, cyc), rd, erd);
        chk($sformatf("err%0d@%0d", k, cyc), 32'(er), 32'(ev && bad(paddr[k])));
    endtask
    initial begin
        for (int k = 0; k < 2; k++) begin
            busy[k] = 1'b0;
            rcyc[k] = -1;
            for (int i = 0; i < 64; i++) mem[k][i] = 32'h0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) busy[k] = 1'b0;
                else if (busy[k] && cyc == rcyc[k]) begin
                    if (pwe[k] && !bad(paddr[k])) mem[k][paddr[k][7:2]] = pwd[k];
                    busy[k] = 1'b0;
                end else if (!busy[k] && bus.req_valid) begin
                    busy[k]  = 1'b1;
                    pwe[k]   = bus.req_we;
                    paddr[k] = bus.req_addr;
                    pwd[k]   = bus.req_wdata;
                    rcyc[k]  = cyc + 1 + (k == 0 ? 2 : 0);
                end
            end
            cyc++;
            @(negedge clk);
            check_inst(0, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
            check_inst(1, bus_f.req_ready, bus_f.rsp_valid, bus_f.rsp_rdata, bus_f.rsp_err);
        end
    end
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic [31:0] rd_f,
                          output logic er, output logic er_f, output int lat, output int lat_f);
        rd = 32'h0; rd_f = 32'h0; er = 1'b0; er_f = 1'b0; lat = 0; lat_f = 0;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 20 && (lat == 0 || lat_f == 0); i++) begin
            if (bus.rsp_valid && lat == 0) begin lat = i; rd = bus.rsp_rdata; er = bus.rsp_err; end
            if (bus_f.rsp_valid && lat_f == 0) begin lat_f = i; rd_f = bus_f.rsp_rdata; er_f = bus_f.rsp_err; end
            @(negedge clk);
        end
    endtask
    logic [31:0] rd, rd_f, a;
    logic        er, er_f;
    int          lat, lat_f, n, sel;
    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h0C; bus.req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0; bus.req_valid = 1'b0;
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
        chk("valid_after_rst", 32'(bus.rsp_valid), 32'd0);
        do_req(1'b0, 32'h0C, 32'h0, rd, rd_f, er, er_f, lat, lat_f);
        chk("rst_no_write", rd, 32'h0);
        chk("rst_no_write_f", rd_f, 32'h0);
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, rd, rd_f, er, er_f, lat, lat_f);
        chk("store_lat", 32'(lat), 32'd3);
        chk("store_lat_f", 32'(lat_f), 32'd1);
        chk("store_rdata", rd, 32'h0);
        chk("store_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h10, 32'h0, rd, rd_f, er, er_f, lat, lat_f);
        chk("load_lat", 32'(lat), 32'd3);
        chk("load_rdata", rd, 32'hDEAD_BEEF);
        chk("load_rdata_f", rd_f, 32'hDEAD_BEEF);
        bus.req_valid = 1'b1; bus.req_addr = 32'h20;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.req_ready) n++;
            bus.req_we = 1'($urandom_range(1));
            bus.req_addr = $urandom_range(1) ? 32'h20 : 32'h24;
            bus.req_wdata = $urandom;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("accepts_per_16", 32'(n), 32'd4);
        do_req(1'b0, 32'h13, 32'h0, rd, rd_f, er, er_f, lat, lat_f);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_rdata", rd, 32'h0);
        chk("misalign_err_f", 32'(er_f), 32'd1);
        do_req(1'b1, 32'h100, 32'h55AA_55AA, rd, rd_f, er, er_f, lat, lat_f);
        chk("range_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h0, 32'h0, rd, rd_f, er, er_f, lat, lat_f);
        chk("word0_kept", rd, 32'h0);
        chk("word0_kept_f", rd_f, 32'h0);
        do_req(1'b1, 32'h04, 32'h1234_5678, rd, rd_f, er, er_f, lat, lat_f);
        do_req(1'b0, 32'h04, 32'h0, rd, rd_f, er, er_f, lat, lat_f);
        chk("w0_lat", 32'(lat_f), 32'd1);
        chk("w0_rdata", rd_f, 32'h1234_5678);
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h08; bus.req_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        do_req(1'b0, 32'h08, 32'h0, rd, rd_f, er, er_f, lat, lat_f);
        chk("midrst_old", rd, 32'h0);
        chk("midrst_old_f", rd_f, 32'h0);
        for (int i = 0; i < 400; i++) begin
            rst = $urandom_range(99) == 0;
            bus.req_valid = $urandom_range(9) < 7;
            bus.req_we = 1'($urandom_range(1));
            bus.req_wdata = $urandom;
            sel = int'($urandom_range(9));
            if (sel < 3) a = {24'h0, 6'($urandom_range(63)), 2'b00};
            else if (sel < 7) a = {24'h0, 3'b000, 3'($urandom_range(7)), 2'b00};
            else if (sel == 7) a = {24'h0, 3'b000, 3'($urandom_range(7)), 2'($urandom_range(1, 3))};
            else if (sel == 8) a = {24'($urandom_range(1, 255)), 8'($urandom_range(255))};
            else a = $urandom;
            bus.req_addr = a;
            @(negedge clk);
        end
        rst = 1'b0; bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
